// File: rtl/comp_acc.sv
// comp_acc: complex accumulate-and-dump stage.
// Sums N_ACC complex products, with saturation, and dumps each frame sum
// together with a one-cycle valid pulse and a sticky per-frame overflow flag.
module comp_acc #(
  parameter int IN_W  = 17,
  parameter int ACC_W = 20,
  parameter int N_ACC = 8
) (
  input  logic                    clk,
  input  logic                    rst,      // asynchronous, active low
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [IN_W-1:0]  i_r,
  input  logic signed [IN_W-1:0]  i_i,
  output logic signed [ACC_W-1:0] o_r,
  output logic signed [ACC_W-1:0] o_i,
  output logic                    o_valid,
  output logic                    o_ovf,
  output logic                    o_busy
);

  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = $clog2(N_ACC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic                    flag_q, flag_d;
  logic signed [ACC_W-1:0] o_r_q, o_r_d, o_i_q, o_i_d;
  logic                    o_valid_q, o_valid_d;
  logic                    o_ovf_q, o_ovf_d;

  // Add one sign-extended sample to the accumulator, clipping to the ACC_W range.
  function automatic logic signed [ACC_W-1:0] sat_add(
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [IN_W-1:0]  b,
    output logic                    ovf
  );
    logic signed [SUM_W-1:0] s;
    logic signed [ACC_W-1:0] res;
    s   = SUM_W'(a) + SUM_W'(b);
    ovf = s[SUM_W-1] ^ s[SUM_W-2];
    if (!ovf)            res = s[ACC_W-1:0];
    else if (s[SUM_W-1]) res = ACC_MIN;
    else                 res = ACC_MAX;
    return res;
  endfunction

  logic signed [ACC_W-1:0] sum_r, sum_i;
  logic                    ovf_r, ovf_i;

  // Saturating sums of the accumulator and the incoming sample; acc is zero in IDLE.
  always_comb begin
    sum_r = sat_add(acc_r_q, i_r, ovf_r);
    sum_i = sat_add(acc_i_q, i_i, ovf_i);
  end

  // Next-state logic: clear beats accept, the last sample dumps and restarts.
  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_r_d   = acc_r_q;
    acc_i_d   = acc_i_q;
    flag_d    = flag_q;
    o_r_d     = o_r_q;
    o_i_d     = o_i_q;
    o_ovf_d   = o_ovf_q;
    o_valid_d = 1'b0;

    if (i_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_r_d = '0;
      acc_i_d = '0;
      flag_d  = 1'b0;
    end else if (i_en) begin
      if (state_q == ACC && cnt_q == CNT_LAST) begin
        o_r_d     = sum_r;
        o_i_d     = sum_i;
        o_ovf_d   = flag_q | ovf_r | ovf_i;
        o_valid_d = 1'b1;
        state_d   = IDLE;
        cnt_d     = '0;
        acc_r_d   = '0;
        acc_i_d   = '0;
        flag_d    = 1'b0;
      end else begin
        state_d = ACC;
        cnt_d   = cnt_q + CNT_W'(1);
        acc_r_d = sum_r;
        acc_i_d = sum_i;
        flag_d  = flag_q | ovf_r | ovf_i;
      end
    end
  end

  // State and output registers; reset discards any partial frame.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_r_q   <= '0;
      acc_i_q   <= '0;
      flag_q    <= 1'b0;
      o_r_q     <= '0;
      o_i_q     <= '0;
      o_valid_q <= 1'b0;
      o_ovf_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_r_q   <= acc_r_d;
      acc_i_q   <= acc_i_d;
      flag_q    <= flag_d;
      o_r_q     <= o_r_d;
      o_i_q     <= o_i_d;
      o_valid_q <= o_valid_d;
      o_ovf_q   <= o_ovf_d;
    end
  end

  assign o_r     = o_r_q;
  assign o_i     = o_i_q;
  assign o_valid = o_valid_q;
  assign o_ovf   = o_ovf_q;
  assign o_busy  = (state_q == ACC);

endmodule

// File: tb/tb_comp_acc.sv
// tb_comp_acc: directed self-checking bench for comp_acc (default build plus a
// small ACC_W=18 / N_ACC=3 build for saturation).
module tb_comp_acc;

  logic clk = 1'b0;
  logic rst;

  // Default-parameter DUT
  logic               en, clr;
  logic signed [16:0] in_r, in_i;
  logic signed [19:0] out_r, out_i;
  logic               out_valid, out_ovf, out_busy;

  // Narrow-accumulator DUT
  logic               en2, clr2;
  logic signed [16:0] in_r2, in_i2;
  logic signed [17:0] out_r2, out_i2;
  logic               out_valid2, out_ovf2, out_busy2;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  int vcnt2  = 0;
  int base;

  always #5 clk = ~clk;

  comp_acc dut (
    .clk(clk), .rst(rst), .i_en(en), .i_clr(clr), .i_r(in_r), .i_i(in_i),
    .o_r(out_r), .o_i(out_i), .o_valid(out_valid), .o_ovf(out_ovf), .o_busy(out_busy)
  );

  comp_acc #(.IN_W(17), .ACC_W(18), .N_ACC(3)) dut2 (
    .clk(clk), .rst(rst), .i_en(en2), .i_clr(clr2), .i_r(in_r2), .i_i(in_i2),
    .o_r(out_r2), .o_i(out_i2), .o_valid(out_valid2), .o_ovf(out_ovf2), .o_busy(out_busy2)
  );

  // Count valid pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (out_valid)  vcnt++;
    if (out_valid2) vcnt2++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are read 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input int r, input int i);
    en   = e;
    clr  = c;
    in_r = 17'(r);
    in_i = 17'(i);
    tick();
  endtask

  initial begin
    rst = 1'b0; en = 0; clr = 0; in_r = 0; in_i = 0;
    en2 = 0; clr2 = 0; in_r2 = 0; in_i2 = 0;

    // 1: reset, then idle
    repeat (4) tick();
    check("rst_o_r", out_r, 0);
    check("rst_o_valid", out_valid, 0);
    rst = 1'b1;
    repeat (20) tick();
    check("idle_o_r", out_r, 0);
    check("idle_o_i", out_i, 0);
    check("idle_o_ovf", out_ovf, 0);
    check("idle_o_busy", out_busy, 0);
    check("idle_no_valid", vcnt, 0);

    // 2: eight samples of 13+13j
    for (int k = 0; k < 7; k++) drive(1, 0, 13, 13);
    check("t2_busy_mid", out_busy, 1);
    check("t2_no_early_valid", vcnt, 0);
    drive(1, 0, 13, 13);
    check("t2_valid", out_valid, 1);
    check("t2_o_r", out_r, 104);
    check("t2_o_i", out_i, 104);
    check("t2_o_ovf", out_ovf, 0);
    check("t2_busy_after", out_busy, 0);
    drive(0, 0, 0, 0);
    check("t2_pulse_one_cycle", out_valid, 0);
    check("t2_o_r_hold", out_r, 104);

    // 3: sixteen back-to-back samples of -1+2j
    base = vcnt;
    for (int k = 0; k < 8; k++) drive(1, 0, -1, 2);
    check("t3_valid_a", out_valid, 1);
    check("t3_o_r_a", out_r, -8);
    check("t3_o_i_a", out_i, 16);
    drive(1, 0, -1, 2);
    check("t3_no_bubble_busy", out_busy, 1);
    check("t3_valid_low", out_valid, 0);
    for (int k = 0; k < 7; k++) drive(1, 0, -1, 2);
    check("t3_valid_b", out_valid, 1);
    check("t3_o_r_b", out_r, -8);
    check("t3_o_i_b", out_i, 16);
    drive(0, 0, 0, 0);
    check("t3_pulses", vcnt - base, 2);

    // 4: saturation on the narrow build, then a clean frame
    for (int k = 0; k < 3; k++) begin
      en2 = 1; in_r2 = 17'sd65535; in_i2 = -17'sd65536;
      tick();
    end
    check("t4_valid", out_valid2, 1);
    check("t4_o_r", out_r2, 131071);
    check("t4_o_i", out_i2, -131072);
    check("t4_o_ovf", out_ovf2, 1);
    for (int k = 0; k < 3; k++) begin
      en2 = 1; in_r2 = 17'sd1; in_i2 = -17'sd2;
      tick();
    end
    en2 = 0;
    check("t4_clean_o_r", out_r2, 3);
    check("t4_clean_o_i", out_i2, -6);
    check("t4_clean_o_ovf", out_ovf2, 0);
    tick();
    check("t4_pulses", vcnt2, 2);

    // 5: abort a partial frame with clr while en is high
    base = vcnt;
    for (int k = 0; k < 5; k++) drive(1, 0, 13, 13);
    drive(1, 1, 13, 13);
    check("t5_clr_busy", out_busy, 0);
    check("t5_clr_no_valid", out_valid, 0);
    check("t5_clr_o_r_hold", out_r, -8);
    for (int k = 0; k < 8; k++) drive(1, 0, 1, 0);
    check("t5_valid", out_valid, 1);
    check("t5_o_r", out_r, 8);
    check("t5_o_i", out_i, 0);
    drive(0, 0, 0, 0);
    check("t5_pulses", vcnt - base, 1);

    // 6: reset mid-frame with a gapped enable
    base = vcnt;
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 2, 3);
      drive(0, 0, 2, 3);
    end
    check("t6_busy_gaps", out_busy, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_o_r", out_r, 0);
    check("t6_rst_o_i", out_i, 0);
    check("t6_rst_busy", out_busy, 0);
    tick();
    rst = 1'b1;
    check("t6_no_valid_aborted", vcnt - base, 0);
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 2, 3);
      if (k == 7) begin
        check("t6_valid", out_valid, 1);
        check("t6_o_r", out_r, 16);
        check("t6_o_i", out_i, 24);
      end
      drive(0, 0, 2, 3);
    end
    check("t6_pulses", vcnt - base, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
